// File: rtl/opb_swreg_bank_pkg.sv
// Shared types and sizes for the OPB software register bank.
package opb_swreg_bank_pkg;

   localparam int unsigned NUM_RW = 4;  // writable registers, driven onto reg_out
   localparam int unsigned NUM_RO = 4;  // read-only registers, sampled from reg_in
   localparam int unsigned IDX_W  = 3;  // word index width (eight words)

   typedef enum logic [1:0] {
      StIdle,
      StLatch,
      StAck
   } state_e;

endpackage

// File: rtl/opb_addr_decode.sv
// Address window decode: hit qualification and word index extraction.
module opb_addr_decode
   import opb_swreg_bank_pkg::*;
#(
   parameter logic [31:0] BaseAddr = 32'h0001_0000,
   parameter logic [31:0] HighAddr = 32'h0001_00FF
) (
   input  logic [31:0]      addr_i,
   input  logic             select_i,
   output logic             hit_o,
   output logic [IDX_W-1:0] idx_o
);

   // Word index comes from byte-address bits 4:2, so the eight words alias across the window.
   always_comb begin
      hit_o = select_i && (addr_i >= BaseAddr) && (addr_i <= HighAddr);
      idx_o = addr_i[IDX_W+1:2];
   end

endmodule

// File: rtl/opb_swreg_bank.sv
// OPB slave exposing four writable and four read-only 32-bit registers.
module opb_swreg_bank
   import opb_swreg_bank_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR = 32'h0001_0000,
   parameter logic [31:0] C_HIGHADDR = 32'h0001_00FF
) (
   input  logic                OPB_Clk,
   input  logic                OPB_Rst,
   input  logic [0:31]         OPB_ABus,
   input  logic [0:3]          OPB_BE,
   input  logic [0:31]         OPB_DBus,
   input  logic                OPB_RNW,
   input  logic                OPB_select,
   input  logic                OPB_seqAddr,
   output logic [0:31]         Sl_DBus,
   output logic                Sl_xferAck,
   output logic                Sl_errAck,
   output logic                Sl_retry,
   output logic                Sl_toutSup,
   output logic [NUM_RW*32-1:0] reg_out,
   input  logic [NUM_RO*32-1:0] reg_in,
   output logic [NUM_RW-1:0]   wr_strobe
);

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q;
   logic                   rnw_q;
   logic [3:0]             be_q;
   logic [31:0]            wdata_q;
   logic [NUM_RO*32-1:0]   snap_q;
   logic [NUM_RW*32-1:0]   regs_q, regs_d;
   logic [NUM_RW-1:0]      strobe_q, strobe_d;

   logic [31:0]            abus;
   logic                   hit;
   logic [IDX_W-1:0]       idx;
   logic                   ack;
   logic                   is_ro;
   logic                   wr_ok;
   logic [1:0]             word_sel;
   logic [31:0]            rd_word;
   logic                   unused_seqaddr;

   // Big-endian bus vectors copy positionally, so numeric values are preserved.
   assign abus           = OPB_ABus;
   assign unused_seqaddr = OPB_seqAddr;
   assign Sl_retry       = 1'b0;
   assign Sl_toutSup     = 1'b0;
   assign reg_out        = regs_q;
   assign wr_strobe      = strobe_q;

   opb_addr_decode #(
      .BaseAddr (C_BASEADDR),
      .HighAddr (C_HIGHADDR)
   ) u_decode (
      .addr_i   (abus),
      .select_i (OPB_select),
      .hit_o    (hit),
      .idx_o    (idx)
   );

   // Next-state: one ack per hit; a dropped select in LATCH abandons the transfer.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (hit) state_d = StLatch;
         StLatch: state_d = OPB_select ? StAck : StIdle;
         StAck:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Ack-cycle decode; reset masks the ack combinationally so an aborted cycle shows nothing.
   always_comb begin
      ack      = (state_q == StAck) && !OPB_Rst;
      is_ro    = idx_q[IDX_W-1];
      word_sel = idx_q[1:0];
      wr_ok    = ack && !rnw_q && !is_ro;
      rd_word  = is_ro ? snap_q[32*int'(word_sel) +: 32] : regs_q[32*int'(word_sel) +: 32];
      Sl_xferAck = ack;
      Sl_errAck  = ack && !rnw_q && is_ro;
      Sl_DBus    = (ack && rnw_q) ? rd_word : '0;
   end

   // Byte-merged register update and strobe for an accepted write.
   always_comb begin
      regs_d   = regs_q;
      strobe_d = '0;
      if (wr_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b]) begin
               regs_d[32*int'(word_sel) + 8*b +: 8] = wdata_q[8*b +: 8];
            end
         end
         strobe_d[word_sel] = 1'b1;
      end
   end

   // State, register file, and transfer capture in LATCH; reset overrides everything.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         state_q  <= StIdle;
         regs_q   <= '0;
         strobe_q <= '0;
         idx_q    <= '0;
         rnw_q    <= 1'b0;
         be_q     <= '0;
         wdata_q  <= '0;
         snap_q   <= '0;
      end else begin
         state_q  <= state_d;
         regs_q   <= regs_d;
         strobe_q <= strobe_d;
         if (state_q == StLatch) begin
            idx_q   <= idx;
            rnw_q   <= OPB_RNW;
            be_q    <= OPB_BE;
            wdata_q <= OPB_DBus;
            snap_q  <= reg_in;
         end
      end
   end

endmodule

// File: doc/opb_swreg_bank.md
OPB_SWREG_BANK -- requirements
Module: opb_swreg_bank

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h0001_0000, the base byte address of the bank.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h0001_00FF, the top byte address of the decode window.
REQ-003 SHALL have port OPB_Clk, input, 1, the single clock.
REQ-004 SHALL have port OPB_Rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port OPB_ABus, input, [0:31], the bus address.
REQ-006 SHALL have port OPB_BE, input, [0:3], byte enables; BE[0] maps to DBus[0:7].
REQ-007 SHALL have port OPB_DBus, input, [0:31], write data from the bridge master.
REQ-008 SHALL have port OPB_RNW, input, 1; 1 = read, 0 = write.
REQ-009 SHALL have port OPB_select, input, 1, transfer valid.
REQ-010 SHALL have port OPB_seqAddr, input, 1; the block ignores it.
REQ-011 SHALL have port Sl_DBus, output, [0:31], read data.
REQ-012 SHALL have port Sl_xferAck, output, 1, transfer acknowledge.
REQ-013 SHALL have port Sl_errAck, output, 1, error acknowledge.
REQ-014 SHALL have port Sl_retry, output, 1, tied 0.
REQ-015 SHALL have port Sl_toutSup, output, 1, tied 0.
REQ-016 SHALL have port reg_out, output, [127:0], writable registers 0..3; register n occupies bits [32n+31:32n].
REQ-017 SHALL have port reg_in, input, [127:0], fabric values for read-only registers 4..7; register 4+n occupies bits [32n+31:32n].
REQ-018 SHALL have port wr_strobe, output, [3:0], a one-cycle pulse per writable register that is written.

Function
REQ-019 Hit SHALL be OPB_select=1 with C_BASEADDR <= OPB_ABus <= C_HIGHADDR; word index = byte-address bits 4:2 (OPB_ABus[27:29]); eight words, aliased across the window.
REQ-020 FSM states SHALL be IDLE, LATCH, ACK; IDLE->LATCH on hit; LATCH->ACK if OPB_select is still 1, else LATCH->IDLE; ACK->IDLE unconditionally.
REQ-021 In LATCH the block SHALL register index, RNW, BE and write data, and SHALL snapshot reg_in; read data therefore reflects reg_in one cycle before the ack.
REQ-022 Sl_xferAck SHALL be 1 only in the ACK cycle; latency from the first select cycle to the ack SHALL be exactly 2 cycles.
REQ-023 Sl_DBus SHALL be all zero except during an ACK read, so the bus can be OR-combined.
REQ-024 A write to index 0..3 in ACK SHALL update only the bytes whose BE bit is 1 and SHALL pulse the matching wr_strobe bit, even when BE=0000.
REQ-025 A write to index 4..7 SHALL assert Sl_errAck together with Sl_xferAck and SHALL leave all state and wr_strobe unchanged.
REQ-026 A read of index 0..3 SHALL return reg_out; a read of index 4..7 SHALL return the reg_in snapshot; all BE lanes SHALL be returned regardless of BE.
REQ-027 If OPB_select is still 1 in the cycle after ACK, the block SHALL treat it as a new transfer (IDLE hit); there SHALL be no back-to-back acks.
REQ-028 If select drops in LATCH, the block SHALL produce no ack, no write and no strobe.

Reset
REQ-029 While OPB_Rst=1 at a clock edge: FSM to IDLE; reg_out = 0; wr_strobe = 0; Sl_xferAck, Sl_errAck = 0; Sl_DBus = 0.
REQ-030 Reset asserted in LATCH or ACK SHALL abort the transfer with no write and no ack in that cycle; reset SHALL take priority over all events.

Structure
REQ-031 A shared package SHALL hold the FSM state type, NUM_RW = 4, NUM_RO = 4 and the word-index width (3).
REQ-032 One sub-module, opb_addr_decode (hit and index, combinational), SHALL be instantiated; everything else stays in one module.

Verification
REQ-033 Reset, then write 0xDEADBEEF to base+0x04 with BE=1111 -> ack 2 cycles after select; reg_out[63:32] = 0xDEADBEEF; wr_strobe = 0010 for one cycle.
REQ-034 Write 0x11223344 to base+0x00 with BE=0100 over the value 0xAAAAAAAA -> reg_out[31:0] = 0xAA22AAAA.
REQ-035 reg_in[31:0] = 0x12345678; read base+0x10 -> Sl_DBus = 0x12345678 in the ack cycle and 0 in all other cycles.
REQ-036 Write to base+0x14 -> Sl_errAck and Sl_xferAck both 1 for one cycle; reg_out and wr_strobe unchanged.
REQ-037 Select held for 1 cycle only -> no ack; address 0x0002_0000 -> no ack ever.
REQ-038 OPB_Rst asserted during ACK of a write to base+0x08 -> reg_out[95:64] = 0; no strobe; no ack.
